vga_timing: RTL

//  Display-side timing generator feeding the game renderer: produces the
//  (vga_row, vga_col) scan position the renderer decodes, registers the

---
 rtl/vga_timing_if.sv | 27 ++
 rtl/vga_timing.sv | 100 ++++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - renderer-side scan position/colour and VGA connector pins
interface vga_timing_if;
    logic [7:0] rgb_r;
    logic [7:0] rgb_g;
    logic [7:0] rgb_b;
    logic [8:0] vga_row;
    logic [9:0] vga_col;
    logic       frame_end;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;

    modport master (
        input  rgb_r, rgb_g, rgb_b,
        output vga_row, vga_col, frame_end,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
    );

    modport slave (
        output rgb_r, rgb_g, rgb_b,
        input  vga_row, vga_col, frame_end,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
    );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480@60 VGA scan generator with one-pixel registered output stage
module vga_timing #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    vga_timing_if.master vga
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             pix_en;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_last;
    logic             v_last;
    logic             visible;
    logic             hs_act;
    logic             vs_act;
    logic             hs_q;
    logic             vs_q;
    logic             blank_n_q;
    logic [7:0]       r_q;
    logic [7:0]       g_q;
    logic [7:0]       b_q;

    // With CLK_DIV=1 the divider stays at 0 and pix_en is constantly high.
    assign pix_en = (div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign h_last = (h_cnt == 10'(H_TOT - 1));
    assign v_last = (v_cnt == 10'(V_TOT - 1));

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign visible   = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
    assign hs_act    = (h_cnt >= 10'(H_VIS + H_FP)) && (h_cnt < 10'(H_VIS + H_FP + H_SYNC));
    assign vs_act    = (v_cnt >= 10'(V_VIS + V_FP)) && (v_cnt < 10'(V_VIS + V_FP + V_SYNC));

    assign vga.vga_row   = visible ? v_cnt[8:0] : 9'd0;
    assign vga.vga_col   = visible ? h_cnt : 10'd0;
    assign vga.frame_end = pix_en && (h_cnt == 10'(H_VIS - 1)) && (v_cnt == 10'(V_VIS - 1));

    // Sync, blank and colour all sample the same counter state, keeping the pins aligned.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else if (pix_en) begin
            hs_q      <= ~hs_act;
            vs_q      <= ~vs_act;
            blank_n_q <= visible;
            r_q       <= visible ? vga.rgb_r : 8'd0;
            g_q       <= visible ? vga.rgb_g : 8'd0;
            b_q       <= visible ? vga.rgb_b : 8'd0;
        end
    end

    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.VGA_BLANK_N = blank_n_q;
    assign vga.VGA_R       = r_q;
    assign vga.VGA_G       = g_q;
    assign vga.VGA_B       = b_q;
endmodule
